// File: rtl/if_id_pkg.sv
// Shared constants for the fetch->decode skid stage: NOP encoding, field positions, buffer states.
package if_id_pkg;
  localparam logic [15:0] IF_ID_NOP = 16'hF000;

  localparam int OPC_LSB  = 12;
  localparam int RD_LSB   = 8;
  localparam int BRC_LSB  = 8;
  localparam int RS_LSB   = 4;
  localparam int RT_LSB   = 0;
  localparam int IMM8_LSB = 0;
  localparam int TGT_LSB  = 0;

  typedef enum logic [1:0] {EMPTY, FULL1, FULL2} skid_state_e;
endpackage

// File: rtl/if_id_skid_stage_skid_buf2.sv
// skid_buf2: data-agnostic 2-entry skid buffer (main + skid register) with registered ready and flush.
module skid_buf2
  import if_id_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  skid_state_e state;
  logic         rdy_q;
  logic [W-1:0] m_q, s_q;
  logic         in_xfer, out_xfer;

  // Flush forces ready so fetch sees its redirect-cycle beat consumed; out_ready never reaches in_ready.
  assign in_ready  = rdy_q | flush;
  assign out_valid = (state != EMPTY);
  assign out_data  = m_q;
  assign in_xfer   = in_valid & rdy_q;
  assign out_xfer  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
      rdy_q <= 1'b1;
      m_q   <= '0;
      s_q   <= '0;
    end else if (flush) begin
      state <= EMPTY;
      rdy_q <= 1'b1;
    end else begin
      unique case (state)
        EMPTY: if (in_xfer) begin
          m_q   <= in_data;
          state <= FULL1;
        end
        FULL1: begin
          if (in_xfer && out_xfer) m_q <= in_data;
          else if (in_xfer) begin
            s_q   <= in_data;
            rdy_q <= 1'b0;
            state <= FULL2;
          end else if (out_xfer) state <= EMPTY;
        end
        FULL2: if (out_xfer) begin
          m_q   <= s_q;
          rdy_q <= 1'b1;
          state <= FULL1;
        end
        default: begin
          state <= EMPTY;
          rdy_q <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: rtl/if_id_skid_stage.sv
// Fetch->decode stage: skid buffer plus NOP substitution, field decode and optional perf counters
// (counters enabled by defining IF_ID_PERF_CNT_EN).
module if_id_skid_stage
  import if_id_pkg::*;
#(
  parameter int          AW    = 16,
  parameter int          IW    = 16,
  parameter logic [15:0] NOP   = IF_ID_NOP,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IW-1:0]    in_instr,
  input  logic [AW-1:0]    in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IW-1:0]    out_instr,
  output logic [AW-1:0]    out_pc,
  output logic [3:0]       out_opcode,
  output logic [3:0]       out_rd,
  output logic [2:0]       out_br_cond,
  output logic [3:0]       out_rs,
  output logic [3:0]       out_rt,
  output logic [7:0]       out_imm8,
  output logic [11:0]      out_target,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam logic [IW-1:0] NOP_W = IW'(NOP);

  logic [AW+IW-1:0] beat;

  skid_buf2 #(.W(AW+IW)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_pc, in_instr}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (beat)
  );

  assign out_instr   = out_valid ? beat[IW-1:0] : NOP_W;
  assign out_pc      = out_valid ? beat[AW+IW-1:IW] : '0;
  assign out_opcode  = out_instr[OPC_LSB  +: 4];
  assign out_rd      = out_instr[RD_LSB   +: 4];
  assign out_br_cond = out_instr[BRC_LSB  +: 3];
  assign out_rs      = out_instr[RS_LSB   +: 4];
  assign out_rt      = out_instr[RT_LSB   +: 4];
  assign out_imm8    = out_instr[IMM8_LSB +: 8];
  assign out_target  = out_instr[TGT_LSB  +: 12];

`ifdef IF_ID_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  // A flush counts when it kills a held beat or the concurrent incoming one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (out_valid && !out_ready && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
      if (flush && (out_valid || in_valid) && !(&flush_q)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_if_id_skid_stage.sv
// Randomized/directed bench for if_id_skid_stage against a 2-deep FIFO reference model.
module tb_if_id_skid_stage;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [15:0]   in_instr, in_pc, out_instr, out_pc;
  logic [3:0]    out_opcode, out_rd, out_rs, out_rt;
  logic [2:0]    out_br_cond;
  logic [7:0]    out_imm8;
  logic [11:0]   out_target;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  // Reference: FIFO of {pc,instr}, capacity 2, ready = room at cycle start (or flush).
  logic [31:0] q[$];
  int          stall_m, flush_m;
  bit          model_ok = 0;
  logic [15:0] next_pc = 16'h0;

  if_id_skid_stage #(.AW(16), .IW(16), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_opcode(out_opcode), .out_rd(out_rd),
    .out_br_cond(out_br_cond), .out_rs(out_rs), .out_rt(out_rt), .out_imm8(out_imm8),
    .out_target(out_target), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [15:0] ei;
    logic        ev;
    ev = (q.size() > 0);
    ei = ev ? q[0][15:0] : 16'hF000;
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("in_ready", 32'(in_ready), 32'((q.size() < 2) || flush));
    chk("out_instr", 32'(out_instr), 32'(ei));
    if (ev) chk("out_pc", 32'(out_pc), 32'(q[0][31:16]));
    chk("fields", {out_opcode, out_rd, out_br_cond, out_rs, out_rt, out_imm8, out_target},
        32'({ei[15:12], ei[11:8], ei[10:8], ei[7:4], ei[3:0], ei[7:0], ei[11:0]}));
`ifdef IF_ID_PERF_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(stall_m));
    chk("flush_cnt", 32'(flush_cnt), 32'(flush_m));
`else
    chk("stall_cnt", 32'(stall_cnt), 32'h0);
    chk("flush_cnt", 32'(flush_cnt), 32'h0);
`endif
  endtask

  task automatic update_model();
    bit ir, do_out, do_in;
    if (!rst_n) begin
      q.delete();
      stall_m  = 0;
      flush_m  = 0;
      model_ok = 1;
      return;
    end
    ir = (q.size() < 2) || flush;
    if (q.size() > 0 && !out_ready && stall_m < 15) stall_m++;
    if (flush && (q.size() > 0 || in_valid) && flush_m < 15) flush_m++;
    if (flush) q.delete();
    else begin
      do_out = (q.size() > 0) && out_ready;
      do_in  = in_valid && (q.size() < 2);
      if (do_out) void'(q.pop_front());
      if (do_in) q.push_back({in_pc, in_instr});
    end
    if (in_valid && ir) next_pc++;
  endtask

  // One clock: check at negedge, advance the model at posedge, then let the caller redrive.
  task automatic cycle();
    @(negedge clk);
    if (model_ok && rst_n) check_outputs();
    @(posedge clk);
    update_model();
    #1;
    in_pc = next_pc;
  endtask

  task automatic drive(input bit iv, input bit ordy, input bit fl);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    in_instr  = 16'($urandom);
  endtask

  initial begin
    rst_n = 1'b0; in_pc = '0;
    drive(0, 0, 0);
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();  // reset state checked at this negedge

    // stream pc 0..9
    for (int i = 0; i < 10; i++) begin drive(1, 1, 0); cycle(); end
    repeat (2) begin drive(0, 1, 0); cycle(); end

    // backpressure for 3 cycles mid-stream
    repeat (2) begin drive(1, 1, 0); cycle(); end
    repeat (3) begin drive(1, 0, 0); cycle(); end
    repeat (4) begin drive(1, 1, 0); cycle(); end
    repeat (2) begin drive(0, 1, 0); cycle(); end

    // fill to FULL2, then flush with a concurrent beat
    repeat (3) begin drive(1, 0, 0); cycle(); end
    drive(1, 0, 1); cycle();
    drive(0, 0, 0); cycle();
    chk("flush_empty", 32'(out_valid), 32'h0);
    chk("flush_nop", 32'(out_instr), 32'hF000);
`ifdef IF_ID_PERF_CNT_EN
    chk("flush_cnt_dir", 32'(flush_cnt), 32'h1);
`else
    chk("flush_cnt_dir", 32'(flush_cnt), 32'h0);
`endif

    // field decode
    drive(1, 0, 0); in_instr = 16'h2A5C; cycle();
    chk("opcode", 32'(out_opcode), 32'h2);
    chk("rd", 32'(out_rd), 32'hA);
    chk("br_cond", 32'(out_br_cond), 32'h2);
    chk("rs", 32'(out_rs), 32'h5);
    chk("rt", 32'(out_rt), 32'hC);
    chk("imm8", 32'(out_imm8), 32'h5C);
    chk("target", 32'(out_target), 32'hA5C);

    // 20 stall cycles with a held beat
    repeat (20) begin drive(0, 0, 0); cycle(); end
`ifdef IF_ID_PERF_CNT_EN
    chk("stall_sat", 32'(stall_cnt), 32'hF);
`else
    chk("stall_sat", 32'(stall_cnt), 32'h0);
`endif
    chk("stall_stable", 32'(out_instr), 32'h2A5C);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 16) == 0);
      cycle();
    end

    // reset mid-operation overrides a concurrent flush
    repeat (3) begin drive(1, 0, 0); cycle(); end
    drive(1, 0, 1); rst_n = 1'b0; cycle();
    rst_n = 1'b1; drive(0, 0, 0); cycle();
    chk("rst_mid_valid", 32'(out_valid), 32'h0);
    chk("rst_mid_ready", 32'(in_ready), 32'h1);
    chk("rst_mid_cnt", {16'(stall_cnt), 16'(flush_cnt)}, 32'h0);
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
